viterbi_ber_checker: RTL and testbench

Bit-error-rate monitor that sits directly downstream of the Viterbi decoder in the tx/rx chain. It keeps a history of the source bits fed to the convolutional encoder and finds the end-to-end latency automatically. It then compares every decoded bit against the delayed source bit and reports lock status, measured latency, bits compared and bit errors. It is used to measure post-decoder BER under channel error injection.

---
 rtl/viterbi_ber_pkg.sv | 21 ++
 rtl/ber_sat_counter.sv | 22 ++
 rtl/viterbi_ber_checker.sv | 123 ++++++++++++
 tb/tb_viterbi_ber_checker.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_ber_pkg.sv
// Shared types and default sizing for the post-Viterbi BER checker.
package viterbi_ber_pkg;

  localparam int DEF_MAX_LAT      = 64;
  localparam int DEF_WIN          = 32;
  localparam int DEF_LOCK_ERR_MAX = 2;
  localparam int DEF_UNLOCK_ERR   = 8;
  localparam int DEF_CNT_W        = 32;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } ber_state_t;

  // "bit" is a keyword, so the sample payload field is called value.
  typedef struct packed {
    logic valid;
    logic value;
  } hist_entry_t;

endpackage

// File: rtl/ber_sat_counter.sv
// Saturating statistics counter with synchronous clear (clear beats increment).
module ber_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/viterbi_ber_checker.sv
// Finds the source-to-decoder latency by windowed search, then counts
// decoded-bit errors against the delayed source bit while locked.
module viterbi_ber_checker
  import viterbi_ber_pkg::*;
#(
  parameter int MAX_LAT      = DEF_MAX_LAT,
  parameter int WIN          = DEF_WIN,
  parameter int LOCK_ERR_MAX = DEF_LOCK_ERR_MAX,
  parameter int UNLOCK_ERR   = DEF_UNLOCK_ERR,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int LAT_W        = $clog2(MAX_LAT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ref_valid_i,
  input  logic             ref_bit_i,
  input  logic             dec_valid_i,
  input  logic             dec_bit_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic [LAT_W-1:0] latency_o,
  output logic [CNT_W-1:0] bit_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             err_pulse_o
);

  localparam int WCNT_W = $clog2(WIN + 1);
  localparam int WERR_W = $clog2(WIN + 1);

  hist_entry_t       hist [MAX_LAT];
  hist_entry_t       hist_sel;
  ber_state_t        state, state_nxt;
  logic [LAT_W-1:0]  cand, cand_nxt, cand_inc;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic [WERR_W-1:0] werr, werr_nxt, werr_tot;
  logic              cmp, mis, win_close;
  logic              bit_inc, err_inc, err_pulse;

  // Entry k holds the source sample from k+1 cycles ago.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LAT; i++) hist[i] <= '0;
    end else begin
      hist[0] <= '{valid: ref_valid_i, value: ref_bit_i};
      for (int i = 1; i < MAX_LAT; i++) hist[i] <= hist[i-1];
    end
  end

  assign hist_sel  = hist[cand];
  assign cmp       = dec_valid_i & hist_sel.valid;
  assign mis       = cmp & (dec_bit_i ^ hist_sel.value);
  assign werr_tot  = werr + WERR_W'(mis);
  assign win_close = cmp && (wcnt == WCNT_W'(WIN - 1));
  assign cand_inc  = (cand == LAT_W'(MAX_LAT - 1)) ? '0 : cand + LAT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SEARCH;
      cand      <= '0;
      wcnt      <= '0;
      werr      <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      cand      <= cand_nxt;
      wcnt      <= wcnt_nxt;
      werr      <= werr_nxt;
      err_pulse <= err_inc;
    end
  end

  // Only compare events move the window; the closing compare's mismatch counts.
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    wcnt_nxt  = wcnt;
    werr_nxt  = werr;
    if (win_close) begin
      wcnt_nxt = '0;
      werr_nxt = '0;
      case (state)
        SEARCH: begin
          if (werr_tot <= WERR_W'(LOCK_ERR_MAX)) state_nxt = LOCKED;
          else                                   cand_nxt  = cand_inc;
        end
        LOCKED: begin
          if (werr_tot >= WERR_W'(UNLOCK_ERR)) begin
            state_nxt = SEARCH;
            cand_nxt  = cand_inc;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end else if (cmp) begin
      wcnt_nxt = wcnt + WCNT_W'(1);
      werr_nxt = werr_tot;
    end
  end

  assign bit_inc = cmp && (state == LOCKED);
  assign err_inc = mis && (state == LOCKED);

  ber_sat_counter #(.CNT_W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_i),
    .inc   (bit_inc),
    .count (bit_cnt_o)
  );

  ber_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_i),
    .inc   (err_inc),
    .count (err_cnt_o)
  );

  assign locked_o    = (state == LOCKED);
  assign latency_o   = cand;
  assign err_pulse_o = err_pulse;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Directed bench: PRBS7 source through a modelled delay line into the checker,
// with a per-cycle scoreboard of expected pulse/lock/latency/counter values.
module tb_viterbi_ber_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ref_valid_i = 1'b0, ref_bit_i = 1'b0;
  logic        dec_valid_i = 1'b0, dec_bit_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        locked_o, err_pulse_o;
  logic [5:0]  latency_o;
  logic [31:0] bit_cnt_o, err_cnt_o;
  logic        s_locked, s_pulse;
  logic [5:0]  s_latency;
  logic [3:0]  s_bit_cnt, s_err_cnt;

  viterbi_ber_checker dut (
    .clk(clk), .rst(rst),
    .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i),
    .dec_valid_i(dec_valid_i), .dec_bit_i(dec_bit_i),
    .clear_i(clear_i),
    .locked_o(locked_o), .latency_o(latency_o),
    .bit_cnt_o(bit_cnt_o), .err_cnt_o(err_cnt_o),
    .err_pulse_o(err_pulse_o)
  );

  viterbi_ber_checker #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst),
    .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i),
    .dec_valid_i(dec_valid_i), .dec_bit_i(dec_bit_i),
    .clear_i(clear_i),
    .locked_o(s_locked), .latency_o(s_latency),
    .bit_cnt_o(s_bit_cnt), .err_cnt_o(s_err_cnt),
    .err_pulse_o(s_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pulse;
    logic       locked;
    logic [5:0] lat;
  } exp_t;

  exp_t       sb[$];
  bit         sent[$];
  int         cyc = 0;
  int         delay = 7;
  bit         ref_en = 1'b1;
  bit         track = 1'b0;
  logic [6:0] lfsr = 7'h7F;
  int         pulse_seen = 0;
  int         n_run = 0, n_fail = 0;

  bit m_locked;
  int m_lat, m_wcnt, m_werr, m_bit, m_err;

  function automatic bit src_at(input int i);
    return (i >= 0) ? sent[i] : 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    exp_t e;
    e = sb.pop_front();
    check("sb_pulse",   err_pulse_o, e.pulse);
    check("sb_locked",  locked_o,    e.locked);
    check("sb_latency", latency_o,   e.lat);
    check("sb_bit_cnt", bit_cnt_o,   m_bit);
    check("sb_err_cnt", err_cnt_o,   m_err);
  endtask

  // Decoder output = source sample from delay+1 edges earlier, i.e. history index delay.
  task automatic apply_stimulus(input bit inject, input bit clr);
    bit   r, mis;
    exp_t e;
    r    = lfsr[6] ^ lfsr[5];
    lfsr = {lfsr[5:0], r};
    sent.push_back(r);
    ref_valid_i = ref_en;
    ref_bit_i   = r;
    dec_valid_i = 1'b1;
    clear_i     = clr;
    dec_bit_i   = src_at(cyc - 1 - delay) ^ inject;
    if (track) begin
      mis     = dec_bit_i ^ src_at(cyc - 1 - m_lat);
      e.pulse = m_locked && mis;
      if (clr) begin
        m_bit = 0;
        m_err = 0;
      end else if (m_locked) begin
        m_bit++;
        m_err += int'(mis);
      end
      m_werr += int'(mis);
      m_wcnt++;
      if (m_wcnt == 32) begin
        if (m_locked && m_werr >= 8) begin
          m_locked = 1'b0;
          m_lat    = (m_lat + 1) % 64;
        end else if (!m_locked) begin
          if (m_werr <= 2) m_locked = 1'b1;
          else             m_lat = (m_lat + 1) % 64;
        end
        m_wcnt = 0;
        m_werr = 0;
      end
      e.locked = m_locked;
      e.lat    = 6'(m_lat);
      sb.push_back(e);
    end
    cyc++;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    pulse_seen += int'(err_pulse_o);
    if (track) check_output();
  endtask

  initial begin
    int steps, hold_bit, hold_err, prev, changes;
    bit seen_lock, walk_ok, wrapped;

    repeat (3) @(posedge clk);
    #1;
    check("rst_locked",  locked_o,    0);
    check("rst_latency", latency_o,   0);
    check("rst_bit_cnt", bit_cnt_o,   0);
    check("rst_err_cnt", err_cnt_o,   0);
    check("rst_pulse",   err_pulse_o, 0);
    rst = 1'b1;

    // Error-free chain at latency 7: candidates 0..6 fail, lock on the 8th window.
    steps = 0;
    do begin
      apply_stimulus(1'b0, 1'b0);
      steps++;
    end while (!locked_o && steps < 400);
    check("lock_d7",       locked_o,  1);
    check("lock_step_d7",  steps,     257);
    check("lat_d7",        latency_o, 7);
    check("search_bits",   bit_cnt_o, 0);
    check("search_errs",   err_cnt_o, 0);
    check("small_locked",  s_locked,  1);
    check("small_latency", s_latency, 7);

    m_locked = 1'b1; m_lat = 7; m_wcnt = 0; m_werr = 0; m_bit = 0; m_err = 0;
    track = 1'b1;
    repeat (1000) apply_stimulus(1'b0, 1'b0);
    check("bits_1000",     bit_cnt_o, 1000);
    check("errs_0",        err_cnt_o, 0);
    check("small_bit_sat", s_bit_cnt, 15);
    check("small_err_0",   s_err_cnt, 0);

    // Clear on a mismatching compare: counters drop to 0, pulse still fires.
    apply_stimulus(1'b1, 1'b1);
    check("clr_pulse",     err_pulse_o, 1);
    check("clr_small_pls", s_pulse,     1);
    check("clr_bits",      bit_cnt_o,   0);
    check("clr_errs",      err_cnt_o,   0);
    check("clr_small_bit", s_bit_cnt,   0);
    check("clr_small_err", s_err_cnt,   0);

    pulse_seen = 0;
    for (int i = 1; i <= 320; i++) apply_stimulus((i % 16) == 0, 1'b0);
    check("inj_errs",      err_cnt_o,  20);
    check("inj_bits",      bit_cnt_o,  320);
    check("inj_pulses",    pulse_seen, 20);
    check("inj_locked",    locked_o,   1);
    check("small_err_sat", s_err_cnt,  15);
    check("small_bit_sat2", s_bit_cnt, 15);

    // Channel delay moves to 8: lose lock, then relock one candidate later.
    delay = 8;
    steps = 0;
    do begin
      apply_stimulus(1'b0, 1'b0);
      steps++;
    end while (locked_o && steps < 200);
    check("unlock_d8", locked_o, 0);
    hold_bit = m_bit;
    hold_err = m_err;
    steps = 0;
    do begin
      apply_stimulus(1'b0, 1'b0);
      steps++;
    end while (!locked_o && steps < 100);
    check("relock_d8",      locked_o,  1);
    check("relock_steps",   steps,     32);
    check("relock_lat",     latency_o, 8);
    check("hold_bits",      bit_cnt_o, hold_bit);
    check("hold_errs",      err_cnt_o, hold_err);
    check("hold_small_err", s_err_cnt, 15);

    // Asynchronous reset mid-window while locked.
    repeat (10) apply_stimulus(1'b0, 1'b0);
    track = 1'b0;
    sb.delete();
    #2 rst = 1'b0;
    #1;
    check("mid_rst_locked",  locked_o,    0);
    check("mid_rst_latency", latency_o,   0);
    check("mid_rst_bits",    bit_cnt_o,   0);
    check("mid_rst_errs",    err_cnt_o,   0);
    check("mid_rst_pulse",   err_pulse_o, 0);
    check("mid_rst_small",   s_err_cnt,   0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Decoded bits with an invalid history never count as compares.
    ref_en = 1'b0;
    repeat (40) apply_stimulus(1'b0, 1'b0);
    check("gap_locked",  locked_o,  0);
    check("gap_latency", latency_o, 0);
    ref_en = 1'b1;
    steps = 0;
    do begin
      apply_stimulus(1'b0, 1'b0);
      steps++;
    end while (!locked_o && steps < 600);
    check("rst_relock",       locked_o,  1);
    check("rst_relock_steps", steps,     289);
    check("rst_relock_lat",   latency_o, 8);
    check("rst_relock_bits",  bit_cnt_o, 0);

    // Delay beyond the history depth: candidate walks the full range and wraps.
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    delay = 70;
    prev = 0; changes = 0; seen_lock = 1'b0; walk_ok = 1'b1; wrapped = 1'b0;
    repeat (2050) begin
      apply_stimulus(1'b0, 1'b0);
      seen_lock |= locked_o;
      if (int'(latency_o) != prev) begin
        changes++;
        if (latency_o != 6'(prev + 1)) walk_ok = 1'b0;
        if (prev == 63 && latency_o == 6'd0) wrapped = 1'b1;
        prev = int'(latency_o);
      end
    end
    check("d70_never_lock", seen_lock, 0);
    check("d70_walk_step",  walk_ok,   1);
    check("d70_wrapped",    wrapped,   1);
    check("d70_changes",    changes,   64);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
